// File: rtl/ctrl_cmd_arbiter_pkg.sv
// Shared definitions for the stopwatch/watch command arbiter: command codes,
// ASCII command letters, FSM states and button bit positions.
package ctrl_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_RUNSTOP = 3'd1,
    CMD_CLEAR   = 3'd2,
    CMD_MODE    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5,
    CMD_SEL     = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_e;

  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_C    = 8'h43;
  localparam logic [7:0] ASCII_M    = 8'h4D;
  localparam logic [7:0] ASCII_U    = 8'h55;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_M_LC = 8'h6D;
  localparam logic [7:0] ASCII_U_LC = 8'h75;
  localparam logic [7:0] ASCII_D_LC = 8'h64;
  localparam logic [7:0] ASCII_S_LC = 8'h73;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

  // Stopwatch commands only make sense in mode 0, watch-set commands in mode 1.
  function automatic logic cmd_mode_ok(input cmd_e cmd, input logic mode);
    case (cmd)
      CMD_RUNSTOP, CMD_CLEAR:    return !mode;
      CMD_UP, CMD_DOWN, CMD_SEL: return mode;
      CMD_MODE:                  return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_cmd_arbiter_uart_cmd_decode.sv
// Combinational UART byte -> command decoder; CR/LF are neither commands nor errors.
module uart_cmd_decode
  import ctrl_cmd_arbiter_pkg::*;
#(
  parameter bit ACCEPT_LOWER = 1'b1
) (
  input  logic [7:0] i_data,
  output logic       o_valid,
  output logic       o_err,
  output cmd_e       o_cmd
);

  logic is_eol;

  always_comb begin
    o_cmd  = CMD_NONE;
    is_eol = 1'b0;
    case (i_data)
      ASCII_R:    o_cmd = CMD_RUNSTOP;
      ASCII_C:    o_cmd = CMD_CLEAR;
      ASCII_M:    o_cmd = CMD_MODE;
      ASCII_U:    o_cmd = CMD_UP;
      ASCII_D:    o_cmd = CMD_DOWN;
      ASCII_S:    o_cmd = CMD_SEL;
      ASCII_R_LC: if (ACCEPT_LOWER) o_cmd = CMD_RUNSTOP;
      ASCII_C_LC: if (ACCEPT_LOWER) o_cmd = CMD_CLEAR;
      ASCII_M_LC: if (ACCEPT_LOWER) o_cmd = CMD_MODE;
      ASCII_U_LC: if (ACCEPT_LOWER) o_cmd = CMD_UP;
      ASCII_D_LC: if (ACCEPT_LOWER) o_cmd = CMD_DOWN;
      ASCII_S_LC: if (ACCEPT_LOWER) o_cmd = CMD_SEL;
      ASCII_CR, ASCII_LF: is_eol = 1'b1;
      default: ;
    endcase
    o_valid = (o_cmd != CMD_NONE);
    o_err   = !o_valid && !is_eol;
  end

endmodule

// File: rtl/ctrl_cmd_arbiter.sv
// Merges button and UART commands into one spaced pulse stream for the
// stopwatch control unit and the watch time-set logic; owns the mode level.
module ctrl_cmd_arbiter
  import ctrl_cmd_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter bit          ACCEPT_LOWER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_btn,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic       o_mode,
  output logic       o_sw_runstop,
  output logic       o_sw_clear,
  output logic       o_wt_up,
  output logic       o_wt_down,
  output logic       o_wt_sel,
  output logic       o_cmd_err,
  output logic       o_drop
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       rr_q, rr_d;
  logic       mode_q, mode_d;
  logic [4:0] pulse_q, pulse_d;
  logic       err_q, err_d;
  logic       drop_q, drop_d;
  logic       btn_vld_q, btn_vld_d;
  logic       rx_vld_q, rx_vld_d;
  cmd_e       btn_slot_q, btn_slot_d;
  cmd_e       rx_slot_q, rx_slot_d;

  logic       dec_valid, dec_err;
  cmd_e       dec_cmd;
  cmd_e       btn_cmd, rx_cmd, gnt_cmd;
  logic       gnt_btn, gnt_rx;

  uart_cmd_decode #(
    .ACCEPT_LOWER(ACCEPT_LOWER)
  ) u_dec (
    .i_data (i_rx_data),
    .o_valid(dec_valid),
    .o_err  (dec_err),
    .o_cmd  (dec_cmd)
  );

  always_comb begin
    btn_cmd = CMD_NONE;
    if (i_btn[BTN_R])      btn_cmd = mode_q ? CMD_SEL  : CMD_RUNSTOP;
    else if (i_btn[BTN_L]) btn_cmd = mode_q ? CMD_NONE : CMD_CLEAR;
    else if (i_btn[BTN_U]) btn_cmd = mode_q ? CMD_UP   : CMD_NONE;
    else if (i_btn[BTN_D]) btn_cmd = mode_q ? CMD_DOWN : CMD_NONE;
    else if (i_btn[BTN_C]) btn_cmd = CMD_MODE;
    rx_cmd = (i_rx_done && dec_valid) ? dec_cmd : CMD_NONE;

    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rr_d      = rr_q;
    mode_d    = mode_q;
    pulse_d   = '0;
    err_d     = i_rx_done && dec_err;
    drop_d    = 1'b0;
    gnt_btn   = 1'b0;
    gnt_rx    = 1'b0;
    gnt_cmd   = CMD_NONE;

    case (state_q)
      ST_IDLE: begin
        // rr_q = 1 favours UART; the pointer only moves when both slots compete.
        if (btn_vld_q && rx_vld_q) begin
          gnt_rx  = rr_q;
          gnt_btn = !rr_q;
          rr_d    = !rr_q;
        end else begin
          gnt_btn = btn_vld_q;
          gnt_rx  = rx_vld_q;
        end
        gnt_cmd = gnt_rx ? rx_slot_q : btn_slot_q;
        if (gnt_btn || gnt_rx) begin
          if (cmd_mode_ok(gnt_cmd, mode_q)) begin
            state_d = ST_ISSUE;
            case (gnt_cmd)
              CMD_RUNSTOP: pulse_d[0] = 1'b1;
              CMD_CLEAR:   pulse_d[1] = 1'b1;
              CMD_UP:      pulse_d[2] = 1'b1;
              CMD_DOWN:    pulse_d[3] = 1'b1;
              CMD_SEL:     pulse_d[4] = 1'b1;
              CMD_MODE:    mode_d     = !mode_q;
              default: ;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A grant frees its slot on the same edge, so a simultaneous capture still lands.
    btn_vld_d  = btn_vld_q && !gnt_btn;
    btn_slot_d = btn_slot_q;
    if (btn_cmd != CMD_NONE) begin
      if (btn_vld_d) begin
        drop_d = 1'b1;
      end else begin
        btn_vld_d  = 1'b1;
        btn_slot_d = btn_cmd;
      end
    end

    rx_vld_d  = rx_vld_q && !gnt_rx;
    rx_slot_d = rx_slot_q;
    if (rx_cmd != CMD_NONE) begin
      if (rx_vld_d) begin
        drop_d = 1'b1;
      end else begin
        rx_vld_d  = 1'b1;
        rx_slot_d = rx_cmd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      rr_q       <= 1'b0;
      mode_q     <= 1'b0;
      pulse_q    <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      btn_vld_q  <= 1'b0;
      rx_vld_q   <= 1'b0;
      btn_slot_q <= CMD_NONE;
      rx_slot_q  <= CMD_NONE;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      rr_q       <= rr_d;
      mode_q     <= mode_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      btn_vld_q  <= btn_vld_d;
      rx_vld_q   <= rx_vld_d;
      btn_slot_q <= btn_slot_d;
      rx_slot_q  <= rx_slot_d;
    end
  end

  assign o_mode       = mode_q;
  assign o_sw_runstop = pulse_q[0];
  assign o_sw_clear   = pulse_q[1];
  assign o_wt_up      = pulse_q[2];
  assign o_wt_down    = pulse_q[3];
  assign o_wt_sel     = pulse_q[4];
  assign o_cmd_err    = err_q;
  assign o_drop       = drop_q;

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
// Scoreboard bench for ctrl_cmd_arbiter: directed stimulus pushes expected output
// events per cycle; negedge monitors pop and compare whenever an event is due or seen.
module tb_ctrl_cmd_arbiter;

  localparam logic [6:0] EV_RS   = 7'b0000001;
  localparam logic [6:0] EV_CLR  = 7'b0000010;
  localparam logic [6:0] EV_UP   = 7'b0000100;
  localparam logic [6:0] EV_SEL  = 7'b0010000;
  localparam logic [6:0] EV_ERR  = 7'b0100000;
  localparam logic [6:0] EV_DROP = 7'b1000000;

  typedef struct {
    int         cyc;
    logic [6:0] ev;
    logic       mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn, btn2;
  logic [7:0] rx_data, rx2_data;
  logic       rx_done, rx2_done;

  logic mode1, rs1, clr1, up1, dn1, sel1, err1, drop1;
  logic mode2, rs2, clr2, up2, dn2, sel2, err2, drop2;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_cmd_arbiter #(.GAP_CYCLES(2), .ACCEPT_LOWER(1'b1)) dut (
    .clk(clk), .rst(rst), .i_btn(btn), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_mode(mode1), .o_sw_runstop(rs1), .o_sw_clear(clr1), .o_wt_up(up1),
    .o_wt_down(dn1), .o_wt_sel(sel1), .o_cmd_err(err1), .o_drop(drop1)
  );

  ctrl_cmd_arbiter #(.GAP_CYCLES(2), .ACCEPT_LOWER(1'b0)) dut_uc (
    .clk(clk), .rst(rst), .i_btn(btn2), .i_rx_data(rx2_data), .i_rx_done(rx2_done),
    .o_mode(mode2), .o_sw_runstop(rs2), .o_sw_clear(clr2), .o_wt_up(up2),
    .o_wt_down(dn2), .o_wt_sel(sel2), .o_cmd_err(err2), .o_drop(drop2)
  );

  wire [6:0] ev1 = {drop1, err1, sel1, dn1, up1, clr1, rs1};
  wire [6:0] ev2 = {drop2, err2, sel2, dn2, up2, clr2, rs2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp1(input int at, input logic [6:0] ev, input logic m);
    exp_t e;
    e.cyc = at; e.ev = ev; e.mode = m;
    q1.push_back(e);
  endtask

  task automatic exp2(input int at, input logic [6:0] ev, input logic m);
    exp_t e;
    e.cyc = at; e.ev = ev; e.mode = m;
    q2.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ev1 != 7'd0 || (q1.size() > 0 && q1[0].cyc == cyc)) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL dut_unexpected cyc=%0d got_ev=%b mode=%b want=none", cyc, ev1, mode1);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.ev !== ev1 || e.mode !== mode1) begin
          bad++;
          $display("FAIL dut_event cyc=%0d got_ev=%b mode=%b want cyc=%0d ev=%b mode=%b",
                   cyc, ev1, mode1, e.cyc, e.ev, e.mode);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ev2 != 7'd0 || (q2.size() > 0 && q2[0].cyc == cyc)) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL uc_unexpected cyc=%0d got_ev=%b mode=%b want=none", cyc, ev2, mode2);
      end else begin
        e = q2.pop_front();
        if (e.cyc != cyc || e.ev !== ev2 || e.mode !== mode2) begin
          bad++;
          $display("FAIL uc_event cyc=%0d got_ev=%b mode=%b want cyc=%0d ev=%b mode=%b",
                   cyc, ev2, mode2, e.cyc, e.ev, e.mode);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    btn = '0; btn2 = '0;
    rx_data = '0; rx2_data = '0;
    rx_done = 1'b0; rx2_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_dut", {mode1, ev1}, 8'h00);
    check("reset_uc", {mode2, ev2}, 8'h00);

    // Single button R in stopwatch mode: pulse two cycles later.
    c = cyc; btn = 5'b00001; exp1(c + 2, EV_RS, 1'b0);
    tick(); btn = '0;
    repeat (8) tick();

    // Button R and UART 'C' together: buttons win, pointer moves to UART.
    c = cyc; btn = 5'b00001; rx_data = "C"; rx_done = 1'b1;
    exp1(c + 2, EV_RS, 1'b0); exp1(c + 6, EV_CLR, 1'b0);
    tick(); btn = '0; rx_done = 1'b0;
    repeat (8) tick();

    // Button L and UART 'R' together: UART now wins, so runstop precedes clear.
    c = cyc; btn = 5'b00010; rx_data = "R"; rx_done = 1'b1;
    exp1(c + 2, EV_RS, 1'b0); exp1(c + 6, EV_CLR, 1'b0);
    tick(); btn = '0; rx_done = 1'b0;
    repeat (8) tick();

    // Watch command in stopwatch mode is rejected at grant; button U is ignored.
    c = cyc; rx_data = "U"; rx_done = 1'b1; exp1(c + 2, EV_ERR, 1'b0);
    tick(); rx_done = 1'b0;
    repeat (4) tick();
    btn = 5'b00100;
    tick(); btn = '0;
    repeat (4) tick();

    // Lower-case 'm','u' back to back; upper-case-only instance flags both.
    c = cyc;
    rx_data = "m"; rx_done = 1'b1; rx2_data = "m"; rx2_done = 1'b1;
    exp1(c + 6, EV_UP, 1'b1);
    exp2(c + 1, EV_ERR, 1'b0); exp2(c + 2, EV_ERR, 1'b0);
    tick();
    check("mode_before_issue", {7'd0, mode1}, 8'h00);
    rx_data = "u"; rx2_data = "u";
    tick(); rx_done = 1'b0; rx2_done = 1'b0;
    check("mode_at_issue", {7'd0, mode1}, 8'h01);
    repeat (8) tick();
    check("uc_mode_unchanged", {7'd0, mode2}, 8'h00);

    // Watch mode: 'R' invalid, LF silent, 'A' bad byte, L+U ignored, R -> SEL.
    c = cyc; rx_data = "R"; rx_done = 1'b1; exp1(c + 2, EV_ERR, 1'b1);
    tick(); rx_done = 1'b0;
    repeat (6) tick();
    rx_data = 8'h0A; rx_done = 1'b1;
    tick(); rx_done = 1'b0;
    repeat (4) tick();
    c = cyc; rx_data = 8'h41; rx_done = 1'b1; exp1(c + 1, EV_ERR, 1'b1);
    tick(); rx_done = 1'b0;
    repeat (4) tick();
    btn = 5'b00110;
    tick(); btn = '0;
    repeat (4) tick();
    c = cyc; btn = 5'b00001; exp1(c + 2, EV_SEL, 1'b1);
    tick(); btn = '0;
    repeat (6) tick();

    // Slot fills during ISSUE; two further bytes in GAP are dropped.
    c = cyc; rx_data = "S"; rx_done = 1'b1;
    exp1(c + 2, EV_SEL, 1'b1); exp1(c + 4, EV_DROP, 1'b1);
    exp1(c + 5, EV_DROP, 1'b1); exp1(c + 6, EV_UP, 1'b1);
    tick(); rx_done = 1'b0;
    tick(); rx_data = "U"; rx_done = 1'b1;
    tick(); rx_data = "D";
    tick(); rx_data = "S";
    tick(); rx_done = 1'b0;
    repeat (8) tick();

    // Reset during ISSUE with both slots holding commands.
    c = cyc; btn = 5'b00100; rx_data = "D"; rx_done = 1'b1;
    exp1(c + 2, EV_UP, 1'b1);
    tick(); btn = 5'b00001; rx_done = 1'b0;
    tick(); btn = '0; rst = 1'b1;
    tick(); rst = 1'b0;
    check("after_reset_dut", {mode1, ev1}, 8'h00);
    repeat (15) tick();

    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL pending_expect got=%0d/%0d want=0/0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
